vga_cursor_ctrl: RTL

//  Grid-cursor controller for the VGA pixel driver: turns player buttons into cell moves
//  and a fire request on the 10x10 board (64x48 px cells). Drives the cursor centre
//  x_pos/y_pos consumed by the pixel driver. Position changes only at frame_start, so a

---
 rtl/vga_cursor_ctrl.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_cursor_ctrl.sv
// vga_cursor_ctrl
// Grid-cursor controller for the VGA pixel driver. Raw player buttons are
// synchronised and debounced, turned into single-cell moves on a
// GRID_COLS x GRID_ROWS board, and applied only on frame_start so that a
// frame never shows a torn cursor. A fire press captures the current cell and
// offers it to the game logic over a valid/ready handshake.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   btn_up/down/left/right/fire  raw asynchronous buttons, active-high
//   frame_start           1-cycle pulse at start of vertical blanking
//   x_pos, y_pos          cursor centre in pixels
//   cell_col, cell_row    cursor cell index
//   fire_valid/col/row    pending fire request and its captured cell
//   fire_ready            consumer accepts the fire request
//
// Configuration macro: AUTOREPEAT_EN -- when defined, a held direction repeats
// its move every REPEAT_FRAMES frame_starts. Undefined: one move per press.
module vga_cursor_ctrl #(
    parameter int GRID_COLS       = 10,
    parameter int GRID_ROWS       = 10,
    parameter int CELL_W          = 64,
    parameter int CELL_H          = 48,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_FRAMES   = 15
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       frame_start,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [3:0] cell_col,
    output logic [3:0] cell_row,
    output logic       fire_valid,
    output logic [3:0] fire_col,
    output logic [3:0] fire_row,
    input  logic       fire_ready
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [9:0] X_FIRST  = 10'(CELL_W / 2);
    localparam logic [9:0] Y_FIRST  = 10'(CELL_H / 2);
    localparam logic [9:0] X_LAST   = 10'((GRID_COLS - 1) * CELL_W + CELL_W / 2);
    localparam logic [9:0] Y_LAST   = 10'((GRID_ROWS - 1) * CELL_H + CELL_H / 2);
    localparam logic [3:0] COL_LAST = 4'(GRID_COLS - 1);
    localparam logic [3:0] ROW_LAST = 4'(GRID_ROWS - 1);

    // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 fire.
    localparam logic [1:0] DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_APPLY} state_t;

    logic [4:0] btn_raw;
    logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0] deb_q, deb_d, deb_dly_q, deb_dly_d;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0] press;

    state_t     state_q, state_d;
    logic [1:0] move_q, move_d;
    logic [3:0] col_q, col_d, row_q, row_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       fv_q, fv_d;
    logic [3:0] fcol_q, fcol_d, frow_q, frow_d;

    logic       dir_valid;
    logic [1:0] dir_sel;
    logic       rep_due;
    logic [1:0] rep_move;

    assign btn_raw = {btn_fire, btn_right, btn_left, btn_down, btn_up};

    // Debounce: the accepted level flips only after DEBOUNCE_CYCLES consecutive
    // synced samples that disagree with it; any agreeing sample restarts the count.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_dly_q;

    // Opposite presses in the same cycle cancel; remaining presses resolve by
    // priority up > down > left > right.
    always_comb begin
        dir_valid = 1'b1;
        dir_sel   = DIR_UP;
        if (press[0] && !press[1]) begin
            dir_sel = DIR_UP;
        end else if (press[1] && !press[0]) begin
            dir_sel = DIR_DOWN;
        end else if (press[2] && !press[3]) begin
            dir_sel = DIR_LEFT;
        end else if (press[3] && !press[2]) begin
            dir_sel = DIR_RIGHT;
        end else begin
            dir_valid = 1'b0;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int RC_W = $clog2(REPEAT_FRAMES + 1);
    logic            rep_valid_q, rep_valid_d;
    logic [1:0]      rep_dir_q, rep_dir_d;
    logic [RC_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_held;

    // The frame that applied a move counts as frame 1 of the repeat period, so
    // the repeat is latched once the count reaches REPEAT_FRAMES and lands on the
    // following frame_start.
    assign rep_held = deb_q[{1'b0, rep_dir_q}];
    assign rep_due  = rep_valid_q && rep_held && (rep_cnt_q >= RC_W'(REPEAT_FRAMES));
    assign rep_move = rep_dir_q;

    always_comb begin
        rep_valid_d = rep_valid_q;
        rep_dir_d   = rep_dir_q;
        rep_cnt_d   = rep_cnt_q;
        if (state_q == S_APPLY) begin
            rep_valid_d = 1'b1;
            rep_dir_d   = move_q;
            rep_cnt_d   = RC_W'(1);
        end else if (rep_valid_q && !rep_held) begin
            rep_valid_d = 1'b0;
            rep_cnt_d   = '0;
        end else if (state_q == S_IDLE && rep_due) begin
            rep_cnt_d = '0;
        end else if (state_q == S_IDLE && frame_start && rep_valid_q
                     && rep_cnt_q < RC_W'(REPEAT_FRAMES)) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rep_valid_q <= 1'b0;
            rep_dir_q   <= DIR_UP;
            rep_cnt_q   <= '0;
        end else begin
            rep_valid_q <= rep_valid_d;
            rep_dir_q   <= rep_dir_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end
`else
    assign rep_due  = 1'b0;
    assign rep_move = DIR_UP;
`endif

    always_comb begin
        state_d = state_q;
        move_d  = move_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (dir_valid) begin
                    state_d = S_PENDING;
                    move_d  = dir_sel;
                end else if (rep_due) begin
                    state_d = S_PENDING;
                    move_d  = rep_move;
                end
            end
            // Only frame_start leaves PENDING, so later presses are ignored here.
            S_PENDING: begin
                if (frame_start) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                case (move_q)
                    DIR_UP: begin
                        if (row_q == '0) begin
                            row_d = ROW_LAST;
                            y_d   = Y_LAST;
                        end else begin
                            row_d = row_q - 1'b1;
                            y_d   = y_q - 10'(CELL_H);
                        end
                    end
                    DIR_DOWN: begin
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            y_d   = Y_FIRST;
                        end else begin
                            row_d = row_q + 1'b1;
                            y_d   = y_q + 10'(CELL_H);
                        end
                    end
                    DIR_LEFT: begin
                        if (col_q == '0) begin
                            col_d = COL_LAST;
                            x_d   = X_LAST;
                        end else begin
                            col_d = col_q - 1'b1;
                            x_d   = x_q - 10'(CELL_W);
                        end
                    end
                    default: begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            x_d   = X_FIRST;
                        end else begin
                            col_d = col_q + 1'b1;
                            x_d   = x_q + 10'(CELL_W);
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fire capture uses the registered cell, so a press during APPLY latches
    // the pre-move position.
    always_comb begin
        fv_d   = fv_q;
        fcol_d = fcol_q;
        frow_d = frow_q;
        if (fv_q) begin
            if (fire_ready) begin
                fv_d = 1'b0;
            end
        end else if (press[4]) begin
            fv_d   = 1'b1;
            fcol_d = col_q;
            frow_d = row_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= S_IDLE;
            move_q  <= DIR_UP;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= X_FIRST;
            y_q     <= Y_FIRST;
            fv_q    <= 1'b0;
            fcol_q  <= '0;
            frow_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            move_q  <= move_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fv_q    <= fv_d;
            fcol_q  <= fcol_d;
            frow_q  <= frow_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign cell_col   = col_q;
    assign cell_row   = row_q;
    assign fire_valid = fv_q;
    assign fire_col   = fcol_q;
    assign fire_row   = frow_q;
endmodule
